// File: rtl/trap_pkg.sv
// Shared definitions for the trap controller: FSM states, exception bit
// positions, mcause codes and machine CSR addresses.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  // Bit positions inside the sticky exception code
  localparam int unsigned EXC_IDX_W = 3;
  localparam logic [EXC_IDX_W-1:0] EXC_FETCH_ERR  = 3'd0;
  localparam logic [EXC_IDX_W-1:0] EXC_DECODE_ERR = 3'd1;
  localparam logic [EXC_IDX_W-1:0] EXC_ANOMALY    = 3'd2;
  localparam logic [EXC_IDX_W-1:0] EXC_ECALL      = 3'd3;
  localparam logic [EXC_IDX_W-1:0] EXC_EBREAK     = 3'd4;

  localparam int unsigned CAUSE_W = 4;
  localparam logic [CAUSE_W-1:0] MCAUSE_MRET   = 4'd0;
  localparam logic [CAUSE_W-1:0] MCAUSE_FETCH  = 4'd1;
  localparam logic [CAUSE_W-1:0] MCAUSE_DECODE = 4'd2;
  localparam logic [CAUSE_W-1:0] MCAUSE_EBREAK = 4'd3;
  localparam logic [CAUSE_W-1:0] MCAUSE_ECALL  = 4'd11;

  localparam int unsigned CSR_ADDR_W = 12;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC  = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC   = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE = 12'h342;

  // mcause value recorded for a given exception bit
  function automatic logic [CAUSE_W-1:0] cause_code(input logic [EXC_IDX_W-1:0] idx);
    case (idx)
      EXC_FETCH_ERR:  cause_code = MCAUSE_FETCH;
      EXC_DECODE_ERR: cause_code = MCAUSE_DECODE;
      EXC_ECALL:      cause_code = MCAUSE_ECALL;
      EXC_EBREAK:     cause_code = MCAUSE_EBREAK;
      default:        cause_code = MCAUSE_MRET;
    endcase
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// Machine trap CSRs (mtvec, mepc, mcause).
// Ports: clk_i/rst_i; CSR bus write (bus_we_i, bus_addr_i, bus_wdata_i);
// trap-entry writes (epc_we_i/epc_i, cause_we_i/cause_i); combinational
// read data for bus_addr_i on rdata_o; mtvec_o/mepc_o feed the FSM.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  bus_we_i,
  input  logic [CSR_ADDR_W-1:0] bus_addr_i,
  input  logic [DATA_WIDTH-1:0] bus_wdata_i,
  input  logic                  epc_we_i,
  input  logic [DATA_WIDTH-1:0] epc_i,
  input  logic                  cause_we_i,
  input  logic [CAUSE_W-1:0]    cause_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] mtvec_o,
  output logic [DATA_WIDTH-1:0] mepc_o
);

  logic [DATA_WIDTH-1:0] mtvec_q, mepc_q, mcause_q;

  // Trap-entry writes take precedence over the bus; the FSM never issues both at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      if (bus_we_i && bus_addr_i == CSR_MTVEC)
        mtvec_q <= {bus_wdata_i[DATA_WIDTH-1:2], 2'b00};
      if (epc_we_i)
        mepc_q <= epc_i;
      else if (bus_we_i && bus_addr_i == CSR_MEPC)
        mepc_q <= bus_wdata_i;
      if (cause_we_i)
        mcause_q <= DATA_WIDTH'(cause_i);
      else if (bus_we_i && bus_addr_i == CSR_MCAUSE)
        mcause_q <= bus_wdata_i;
    end
  end

  // Read mux; unknown addresses read as zero
  always_comb begin
    rdata_o = '0;
    case (bus_addr_i)
      CSR_MTVEC:  rdata_o = mtvec_q;
      CSR_MEPC:   rdata_o = mepc_q;
      CSR_MCAUSE: rdata_o = mcause_q;
      default:    rdata_o = '0;
    endcase
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: takes per-instruction fault/trap events, records mepc and
// mcause, redirects fetch to mtvec (or to mepc on mret) and, when no handler
// is installed, halts with a sticky one-hot exception code.
// Ports: clk_i/rst_i; retiring instruction (valid_i, pc_i, fetch_err_i,
// decode_err_i, ecall_i, ebreak_i, mret_i); CSR bus (csr_we_i, csr_addr_i,
// csr_wdata_i, csr_rdata_o combinational); stall_o, redirect_o,
// redirect_pc_o, exceptions_o.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned EXC_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  fetch_err_i,
  input  logic                  decode_err_i,
  input  logic                  ecall_i,
  input  logic                  ebreak_i,
  input  logic                  mret_i,
  input  logic                  csr_we_i,
  input  logic [CSR_ADDR_W-1:0] csr_addr_i,
  input  logic [DATA_WIDTH-1:0] csr_wdata_i,
  output logic [DATA_WIDTH-1:0] csr_rdata_o,
  output logic                  stall_o,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  output logic [EXC_WIDTH-1:0]  exceptions_o
);

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] lat_pc_q;
  logic [EXC_IDX_W-1:0]  lat_idx_q;
  logic [EXC_WIDTH-1:0]  exc_q;
  logic                  stall_q, redir_q;
  logic [DATA_WIDTH-1:0] redir_pc_q;

  logic                  any_exc;
  logic [EXC_IDX_W-1:0]  exc_idx;
  logic                  lat_we, bus_we, epc_we, cause_we, redir_d;
  logic [CAUSE_W-1:0]    cause_val;
  logic [EXC_WIDTH-1:0]  exc_set;
  logic [DATA_WIDTH-1:0] redir_pc_d, mtvec, mepc;

  // Fault priority: fetch > decode > ecall > ebreak
  always_comb begin
    any_exc = 1'b1;
    exc_idx = EXC_EBREAK;
    if (fetch_err_i)       exc_idx = EXC_FETCH_ERR;
    else if (decode_err_i) exc_idx = EXC_DECODE_ERR;
    else if (ecall_i)      exc_idx = EXC_ECALL;
    else if (ebreak_i)     exc_idx = EXC_EBREAK;
    else                   any_exc = 1'b0;
  end

  trap_csr_file #(.DATA_WIDTH(DATA_WIDTH)) u_csr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bus_we_i    (bus_we),
    .bus_addr_i  (csr_addr_i),
    .bus_wdata_i (csr_wdata_i),
    .epc_we_i    (epc_we),
    .epc_i       (lat_pc_q),
    .cause_we_i  (cause_we),
    .cause_i     (cause_val),
    .rdata_o     (csr_rdata_o),
    .mtvec_o     (mtvec),
    .mepc_o      (mepc)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    lat_we     = 1'b0;
    bus_we     = 1'b0;
    epc_we     = 1'b0;
    cause_we   = 1'b0;
    cause_val  = MCAUSE_MRET;
    exc_set    = '0;
    redir_d    = 1'b0;
    redir_pc_d = '0;
    case (state_q)
      ST_RUN: begin
        if (valid_i && any_exc) begin
          lat_we  = 1'b1;
          state_d = ST_ENTRY;
        end else if (valid_i && mret_i) begin
          if (mepc[1:0] != 2'b00) begin
            exc_set[EXC_ANOMALY] = 1'b1;
            cause_we             = 1'b1;
            cause_val            = MCAUSE_MRET;
            state_d              = ST_HALT;
          end else begin
            redir_d    = 1'b1;
            redir_pc_d = mepc;
            state_d    = ST_REDIRECT;
          end
        end else begin
          bus_we = csr_we_i;
        end
      end
      ST_ENTRY: begin
        epc_we    = 1'b1;
        cause_we  = 1'b1;
        cause_val = cause_code(lat_idx_q);
        if (mtvec == '0) begin
          exc_set = EXC_WIDTH'(1) << lat_idx_q;
          state_d = ST_HALT;
        end else begin
          redir_d    = 1'b1;
          redir_pc_d = mtvec;
          state_d    = ST_REDIRECT;
        end
      end
      ST_REDIRECT: state_d = ST_RUN;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_RUN;
    endcase
  end

  // Latched trap info and registered outputs; exception code is sticky
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_pc_q   <= '0;
      lat_idx_q  <= '0;
      exc_q      <= '0;
      stall_q    <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      if (lat_we) begin
        lat_pc_q  <= pc_i;
        lat_idx_q <= exc_idx;
      end
      exc_q      <= exc_q | exc_set;
      stall_q    <= (state_d != ST_RUN);
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign stall_o       = stall_q;
  assign redirect_o    = redir_q;
  assign redirect_pc_o = redir_pc_q;
  assign exceptions_o  = exc_q;

endmodule
